// File: rtl/firebird_imm_enc_pkg.sv
// Shared types for the immediate encoder: format codes, opcode classes, buffer states.
// Provides the instruction/immediate size defines when the core has not supplied them.
`ifndef FIREBIRD_INSTSUCTION_SIZE
`define FIREBIRD_INSTSUCTION_SIZE 32
`endif
`ifndef FIREBIRD_ALU_CAL_SIZE
`define FIREBIRD_ALU_CAL_SIZE 32
`endif

package firebird_imm_enc_pkg;
  localparam int INST_W = `FIREBIRD_INSTSUCTION_SIZE;
  localparam int IMM_W  = `FIREBIRD_ALU_CAL_SIZE;

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_B   = 2'b10,
    FMT_ILL = 2'b11
  } fmt_e;

  localparam logic [2:0] OPC_CLS_I = 3'b000;
  localparam logic [2:0] OPC_CLS_S = 3'b010;
  localparam logic [2:0] OPC_CLS_B = 3'b110;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Immediate fits a signed 12-bit field when bits [31:11] are a pure sign extension.
  function automatic logic fits_s12(input logic [IMM_W-1:0] imm);
    return (&imm[IMM_W-1:11]) | ~(|imm[IMM_W-1:11]);
  endfunction

  function automatic logic fits_s13(input logic [IMM_W-1:0] imm);
    return (&imm[IMM_W-1:12]) | ~(|imm[IMM_W-1:12]);
  endfunction
endpackage

// File: rtl/firebird_skid_buf2.sv
// Two-entry valid/ready FIFO buffer; the head entry drives the output directly.
module firebird_skid_buf2
  import firebird_imm_enc_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  buf_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign in_ready_o  = (state_q != BUF_TWO);
  assign out_valid_o = (state_q != BUF_EMPTY);
  assign out_data_o  = head_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = in_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = in_data_i;
        end else if (push) begin
          tail_d  = in_data_i;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // No push can arrive here since in_ready is low.
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end
endmodule

// File: rtl/firebird_imm_enc.sv
// Packs opcode/funct3/register fields and a signed immediate into an I/S/B instruction word.
// Optional FIREBIRD_IMM_ENC_ERRCNT_EN adds a saturating err_count output.
module firebird_imm_enc
  import firebird_imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic              out_err,
`ifdef FIREBIRD_IMM_ENC_ERRCNT_EN
  output logic [CNT_W-1:0]  err_count,
`endif
  output logic [CNT_W-1:0]  enc_count
);
  logic [INST_W-1:0] enc_inst;
  logic              enc_err;
  logic              accept;
  logic [CNT_W-1:0]  enc_cnt_q, enc_cnt_d;

  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    case (fmt_e'(in_fmt))
      FMT_I: begin
        enc_err  = (in_opcode[6:4] != OPC_CLS_I) || !fits_s12(in_imm);
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (enc_err) enc_inst[31:20] = '0;
      end
      FMT_S: begin
        enc_err  = (in_opcode[6:4] != OPC_CLS_S) || !fits_s12(in_imm);
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (enc_err) begin
          enc_inst[31:25] = '0;
          enc_inst[11:7]  = '0;
        end
      end
      FMT_B: begin
        enc_err  = (in_opcode[6:4] != OPC_CLS_B) || !fits_s13(in_imm) || in_imm[0];
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        if (enc_err) begin
          enc_inst[31:25] = '0;
          enc_inst[11:7]  = '0;
        end
      end
      default: begin
        enc_err  = 1'b1;
        enc_inst = '0;
      end
    endcase
  end

  firebird_skid_buf2 #(.W(INST_W + 1)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({enc_err, enc_inst}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  ({out_err, out_inst})
  );

  assign accept    = in_valid & in_ready;
  assign enc_cnt_d = (accept && !enc_err) ? enc_cnt_q + 1'b1 : enc_cnt_q;
  assign enc_count = enc_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) enc_cnt_q <= '0;
    else     enc_cnt_q <= enc_cnt_d;
  end

`ifdef FIREBIRD_IMM_ENC_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign err_cnt_d = (accept && enc_err && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  assign err_count = err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end
`endif
endmodule

// File: tb/tb_firebird_imm_enc.sv
// Scoreboard bench for firebird_imm_enc: driver pushes expected words, monitor pops on each pop.
module tb_firebird_imm_enc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;
`ifdef FIREBIRD_IMM_ENC_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int total = 0;
  int bad = 0;
  logic [32:0] sb[$];
  logic [31:0] last_inst = '0;
  logic        stall_seen = 1'b0;
  logic [32:0] stall_word = '0;

  always #5 clk = ~clk;

  firebird_imm_enc #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
`ifdef FIREBIRD_IMM_ENC_ERRCNT_EN
    .err_count(err_count),
`endif
    .enc_count(enc_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-low-phase, pops the scoreboard on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen && out_valid)
          chk("hold_stable", {31'd0, out_err, out_inst}, {31'd0, stall_word});
        stall_seen = 1'b0;
        if (out_valid && !out_ready) begin
          stall_seen = 1'b1;
          stall_word = {out_err, out_inst};
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", {31'd0, out_err, out_inst}, 64'hDEAD_BEEF_DEAD_BEEF);
          end else begin
            logic [32:0] e;
            e = sb.pop_front();
            chk("word", {31'd0, out_err, out_inst}, {31'd0, e});
            last_inst = out_inst;
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_fmt = fmt; in_opcode = opc; in_funct3 = f3;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      sb.push_back({exp_err, exp_inst});
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_enc_count", 64'(enc_count), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // I-type load, negative immediate; output valid one cycle after accept.
    send(2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0);
    chk("latency_valid", 64'(out_valid), 64'd1);
    drain();
    chk("enc_count_1", 64'(enc_count), 64'd1);
    chk("i_decode", 64'({{20{last_inst[31]}}, last_inst[31:20]}), 64'hFFFF_FFFC);

    send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd8, 32'h0000_0010, 32'h0081_2823, 1'b0);
    send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0);
    drain();
    chk("enc_count_3", 64'(enc_count), 64'd3);

    // Error cases: odd branch offset, I immediate out of range, illegal format.
    send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'h0000_0007, 32'h0020_8063, 1'b1);
    drain();
    chk("enc_count_b_err", 64'(enc_count), 64'd3);
    send(2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'h0000_0800, 32'h0001_2283, 1'b1);
    send(2'b11, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd8, 32'h0000_0004, 32'h0000_0000, 1'b1);
    drain();
    chk("enc_count_errs", 64'(enc_count), 64'd3);

    // Backpressure: two accepted, third stalls until the consumer drains.
    @(negedge clk);
    out_ready = 1'b0;
    send(2'b00, 7'b0000011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0083, 1'b0);
    send(2'b00, 7'b0000011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0103, 1'b0);
    @(negedge clk);
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_word", 64'(out_inst), 64'h0010_0083);
    fork
      send(2'b00, 7'b0000011, 3'b000, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0183, 1'b0);
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("enc_count_bp", 64'(enc_count), 64'd6);
`ifdef FIREBIRD_IMM_ENC_ERRCNT_EN
    chk("err_count_3", 64'(err_count), 64'd3);
`endif

    // Reset while two words are buffered.
    @(negedge clk);
    out_ready = 1'b0;
    send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd8, 32'h0000_0010, 32'h0081_2823, 1'b0);
    send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd8, 32'h0000_0010, 32'h0081_2823, 1'b0);
    @(negedge clk);
    #1;
    chk("two_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_enc_count", 64'(enc_count), 64'd0);
`ifdef FIREBIRD_IMM_ENC_ERRCNT_EN
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
`endif
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_word", 64'(out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
